// File: rtl/mem_responder_pkg.sv
// Shared types and widths for the multicycle memory responder.
// Holds the FSM state enum and data/byte-enable/counter widths.
package mem_responder_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/mem_array_be.sv
// Single-port word RAM with per-byte write enables.
// Write is clocked; read port is combinational on the word index.
module mem_array_be
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Byte-lane write; contents are never reset
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder_mc.sv
// Memory-side responder: one outstanding request, fixed wait latency.
// Optional access-error checking enabled by MEM_RESPONDER_ERR_EN.
module mem_responder_mc
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [31:0]       req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [BE_W-1:0]   req_be_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic [AW-1:0]     idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              err_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rsp_err_q;

  logic              idle;
  logic              accept;
  logic              commit;
  logic              req_err;
  logic              cur_we;
  logic [AW-1:0]     cur_idx;
  logic [DATA_W-1:0] cur_wdata;
  logic [BE_W-1:0]   cur_be;
  logic              cur_err;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] rdata_d;

`ifdef MEM_RESPONDER_ERR_EN
  assign req_err = (req_addr_i[1:0] != 2'b00) ||
                   ({2'b00, req_addr_i[31:2]} >= 32'(DEPTH_WORDS));
`else
  logic unused_addr;
  assign unused_addr = ^{req_addr_i[1:0], req_addr_i[31:AW+2]};
  assign req_err     = 1'b0;
`endif

  assign idle        = (state_q == IDLE);
  assign req_ready_o = idle & ~rst_i;
  assign accept      = req_valid_i & req_ready_o;

  // With zero wait states the access commits on the accept edge,
  // so the RAM must see the live request rather than the latch.
  assign cur_we    = idle ? req_we_i : we_q;
  assign cur_idx   = idle ? req_addr_i[AW+1:2] : idx_q;
  assign cur_wdata = idle ? req_wdata_i : wdata_q;
  assign cur_be    = idle ? req_be_i : be_q;
  assign cur_err   = idle ? req_err : err_q;

  assign commit = (state_q == WAIT && cnt_q == CNT_W'(1)) ||
                  (accept && WAIT_CYCLES == 0);
  assign ram_we  = commit & cur_we & ~cur_err;
  assign rdata_d = (cur_we | cur_err) ? '0 : ram_rdata;

  mem_array_be #(
    .DEPTH (DEPTH_WORDS)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .be_i    (cur_be),
    .addr_i  (cur_idx),
    .wdata_i (cur_wdata),
    .rdata_o (ram_rdata)
  );

  // Capture the request fields at accept
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= req_we_i;
      idx_q   <= req_addr_i[AW+1:2];
      wdata_q <= req_wdata_i;
      be_q    <= req_be_i;
      err_q   <= req_err;
    end
  end

  // Control FSM, wait counter and registered response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_q   <= WAIT_LD;
            state_q <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (commit) begin
        rsp_valid_q <= 1'b1;
        rdata_q     <= rdata_d;
        rsp_err_q   <= cur_err;
      end else if (state_q == RESP && rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
        rdata_q     <= '0;
        rsp_err_q   <= 1'b0;
      end
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder_mc.sv
// Scoreboard bench for mem_responder_mc (WAIT_CYCLES 2 and 0).
// Expectations follow MEM_RESPONDER_ERR_EN when it is defined.
module tb_mem_responder_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_a = 1'b0;
  logic        req_valid_b = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_ready = 1'b1;
  logic        req_ready_a, req_ready_b;
  logic        rsp_valid_a, rsp_valid_b;
  logic [31:0] rsp_rdata_a, rsp_rdata_b;
  logic        rsp_err_a, rsp_err_b;

  bit rnd_rdy = 1'b0;
  bit fixed_rdy = 1'b1;
  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  logic [31:0] mdl [2][1024];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1 rsp_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : fixed_rdy;
  end

  mem_responder_mc #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_a), .req_ready_o(req_ready_a),
    .req_we_i(req_we), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid_a), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata_a), .rsp_err_o(rsp_err_a)
  );

  mem_responder_mc #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_b), .req_ready_o(req_ready_b),
    .req_we_i(req_we), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata_b), .rsp_err_o(rsp_err_b)
  );

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Reference: word memory with byte lanes and the address rules
  function automatic exp_t model(int s, bit we, logic [31:0] a,
                                 logic [31:0] wd, logic [3:0] be);
    exp_t e;
    int   idx;
    bit   er;
    idx = int'(a[11:2]);
    er  = 1'b0;
`ifdef MEM_RESPONDER_ERR_EN
    er = (a[1:0] != 2'b00) || (a[31:12] != 20'd0);
`endif
    e.err   = er;
    e.rdata = 32'd0;
    e.acc   = 0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) mdl[s][idx][8*i +: 8] = wd[8*i +: 8];
      end else begin
        e.rdata = mdl[s][idx];
      end
    end
    return e;
  endfunction

  bit va_prev = 1'b0;
  bit vb_prev = 1'b0;

  // Monitor A: latency on rising valid, data/err on handshake
  always @(negedge clk) begin
    exp_t e;
    if (rst) va_prev = 1'b0;
    else begin
      if (rsp_valid_a && !va_prev) begin
        if (qa.size() == 0) chk("spurious_a", 32'(rsp_valid_a), 32'd0);
        else chk("lat_a", cyc, qa[0].acc + 3);
      end
      if (rsp_valid_a && rsp_ready && qa.size() != 0) begin
        e = qa.pop_front();
        chk("rdata_a", rsp_rdata_a, e.rdata);
        chk("err_a", 32'(rsp_err_a), 32'(e.err));
      end
      va_prev = rsp_valid_a;
    end
  end

  // Monitor B: same checks, zero wait states
  always @(negedge clk) begin
    exp_t e;
    if (rst) vb_prev = 1'b0;
    else begin
      if (rsp_valid_b && !vb_prev) begin
        if (qb.size() == 0) chk("spurious_b", 32'(rsp_valid_b), 32'd0);
        else chk("lat_b", cyc, qb[0].acc + 1);
      end
      if (rsp_valid_b && rsp_ready && qb.size() != 0) begin
        e = qb.pop_front();
        chk("rdata_b", rsp_rdata_b, e.rdata);
        chk("err_b", 32'(rsp_err_b), 32'(e.err));
      end
      vb_prev = rsp_valid_b;
    end
  end

  task automatic drive(int s, bit we, logic [31:0] a,
                       logic [31:0] wd, logic [3:0] be);
    @(posedge clk);
    #1;
    req_we = we; req_addr = a; req_wdata = wd; req_be = be;
    if (s == 1) req_valid_b = 1'b1;
    else req_valid_a = 1'b1;
  endtask

  // Wait for accept; returns 1 at the negedge before the accept edge
  task automatic wait_acc(int s, output bit ok);
    int n = 0;
    ok = 1'b0;
    forever begin
      @(negedge clk);
      if ((s == 1) ? req_ready_b : req_ready_a) begin
        ok = 1'b1;
        break;
      end
      if (++n > 200) begin
        chk("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic issue(int s, bit we, logic [31:0] a,
                       logic [31:0] wd, logic [3:0] be);
    bit   ok;
    exp_t e;
    drive(s, we, a, wd, be);
    wait_acc(s, ok);
    if (ok) begin
      e = model(s, we, a, wd, be);
      e.acc = cyc;
      if (s == 1) qb.push_back(e);
      else qa.push_back(e);
    end
    @(posedge clk);
    #1 req_valid_a = 1'b0;
    req_valid_b = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (qa.size() != 0 || qb.size() != 0) begin
      @(negedge clk);
      if (++n > 300) begin
        chk("drain_timeout", 32'(qa.size() + qb.size()), 32'd0);
        qa.delete();
        qb.delete();
      end
    end
  endtask

  initial begin
    bit ok;
    int n;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready_a), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_a), 32'd0);
    chk("rst_rdata", rsp_rdata_a, 32'd0);
    chk("rst_err", 32'(rsp_err_a), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready_a), 32'd1);

    issue(0, 1, 32'h0, 32'hA5A5_5A5A, 4'hF);
    issue(0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    issue(0, 0, 32'h10, 32'h0, 4'h0);
    issue(0, 1, 32'h10, 32'h1122_3344, 4'b0101);
    issue(0, 0, 32'h10, 32'h0, 4'h0);
    drain();
    chk("be0101_merge", mdl[0][4], 32'hDE22_BE44);
    issue(0, 1, 32'h10, 32'hFFFF_FFFF, 4'h0);
    issue(0, 0, 32'h10, 32'h0, 4'h0);
    issue(0, 1, 32'h1000, 32'h5555_AAAA, 4'hF);
    issue(0, 0, 32'h0, 32'h0, 4'h0);
    issue(0, 0, 32'h13, 32'h0, 4'h0);
    issue(0, 1, 32'h20, 32'h0123_4567, 4'hF);
    drain();

    // Reset while the write to 0x20 waits: it must vanish
    drive(0, 1, 32'h20, 32'hCAFE_F00D, 4'hF);
    wait_acc(0, ok);
    @(posedge clk);
    #1 req_valid_a = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("no_rsp_after_rst", 32'(rsp_valid_a), 32'd0);
    end
    issue(0, 0, 32'h20, 32'h0, 4'h0);
    drain();

    // Backpressure: hold the response for five cycles
    @(negedge clk);
    fixed_rdy = 1'b0;
    issue(0, 0, 32'h10, 32'h0, 4'h0);
    n = 0;
    while (!rsp_valid_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      chk("stall_valid", 32'(rsp_valid_a), 32'd1);
      chk("stall_rdata", rsp_rdata_a,
          (qa.size() != 0) ? qa[0].rdata : 32'hBAD0_BAD0);
      chk("stall_ready", 32'(req_ready_a), 32'd0);
    end
    fixed_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_after_hs", 32'(req_ready_a), 32'd1);
    chk("valid_after_hs", 32'(rsp_valid_a), 32'd0);
    drain();

    // Zero wait states
    issue(1, 1, 32'h0, 32'h0BAD_F00D, 4'hF);
    issue(1, 0, 32'h0, 32'h0, 4'h0);
    issue(1, 1, 32'h4, 32'h7777_8888, 4'b0011);
    issue(1, 0, 32'h4, 32'h0, 4'h0);
    drain();

    // Random traffic over a preloaded window
    for (int w = 64; w < 80; w++)
      issue(0, 1, 32'(w << 2), $urandom, 4'hF);
    rnd_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(64, 79) << 2);
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) a[31:12] = 20'($urandom);
      issue(0, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
    end
    drain();
    rnd_rdy = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
